// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned LED_N = 4;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [LED_N-1:0] PAT_OFF    = 4'b0000;
  localparam logic [LED_N-1:0] PAT_BLINK  = 4'b1111;
  localparam logic [LED_N-1:0] PAT_CHASE  = 4'b0001;
  localparam logic [LED_N-1:0] PAT_BOUNCE = 4'b0001;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(2'(m + 2'd1));
  endfunction

  function automatic logic [LED_N-1:0] init_pattern(input mode_t m);
    case (m)
      MODE_OFF:    return PAT_OFF;
      MODE_BLINK:  return PAT_BLINK;
      MODE_CHASE:  return PAT_CHASE;
      MODE_BOUNCE: return PAT_BOUNCE;
      default:     return PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running step counter: pulses tick when the count reaches TICK_CYCLES-1.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_CYCLES);
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = !hold && (cnt == LAST);

  // clear outranks hold so a press during pause still restarts the period
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (!hold) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode-selectable 4-LED pattern sequencer; optional pause input under LED_SEQ_PAUSE_EN.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1000000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Press,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             i_Pause,
`endif
  output logic [LED_N-1:0] o_LED,
  output logic [1:0]       o_Mode,
  output logic             o_Tick
);

  logic             press_r;
  logic             press;
  logic             hold;
  logic             step;
  mode_t            mode, mode_next;
  dir_t             dir, dir_next;
  logic [LED_N-1:0] led, led_next;
  logic             tick_next;

  assign press = i_Press && !press_r;

`ifdef LED_SEQ_PAUSE_EN
  assign hold = i_Pause;
`else
  assign hold = 1'b0;
`endif

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .clear (press),
    .hold  (hold),
    .tick  (step)
  );

  always_comb begin
    mode_next = mode;
    led_next  = led;
    dir_next  = dir;
    tick_next = 1'b0;
    if (press) begin
      mode_next = next_mode(mode);
      led_next  = init_pattern(mode_next);
      dir_next  = DIR_UP;
    end else if (step) begin
      tick_next = 1'b1;
      case (mode)
        MODE_OFF:   led_next = '0;
        MODE_BLINK: led_next = ~led;
        MODE_CHASE: led_next = {led[LED_N-2:0], led[LED_N-1]};
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            led_next = {led[LED_N-2:0], 1'b0};
            if (led_next[LED_N-1]) dir_next = DIR_DOWN;
          end else begin
            led_next = {1'b0, led[LED_N-1:1]};
            if (led_next[0]) dir_next = DIR_UP;
          end
        end
        default: led_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    press_r <= i_Press;
    if (i_Rst) begin
      mode   <= MODE_OFF;
      led    <= '0;
      dir    <= DIR_UP;
      o_Tick <= 1'b0;
    end else begin
      mode   <= mode_next;
      led    <= led_next;
      dir    <= dir_next;
      o_Tick <= tick_next;
    end
  end

  assign o_LED  = led;
  assign o_Mode = mode;

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Controller that sequences a 4-LED bank through selectable display patterns at a programmable tick rate. A debounced button cycles the active mode. The block owns the tick timing, the pattern state machine and the mode selection. It sits between the `debounce` instance on the switch path and the board LED pins, and replaces per-LED ad-hoc blink logic.

## Interface
- `TICK_CYCLES`, default 1000000: clock cycles per pattern step; legal range 2 to 2^32-1.
- `i_Clk`  in  1  system clock.
- `i_Rst`  in  1  reset, synchronous, active-high.
- `i_Press`  in  1  debounced button level; each rising edge advances the mode.
- `i_Pause`  in  1  freeze request; present only with `PAUSE_EN` (see Configuration).
- `o_LED`  out  4  LED drive, registered, bit 0 = LED1.
- `o_Mode`  out  2  current mode, registered.
- `o_Tick`  out  1  one-cycle pulse on every pattern step, registered.

## Operation
- Modes: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE. Order 0→1→2→3→0, wrapping.
- Press detect:
  - `press_r` holds the previous `i_Press`.
  - A press is `i_Press==1 && press_r==0`.
- Tick counter:
  - `cnt` counts 0..`TICK_CYCLES`-1; width is `$clog2(TICK_CYCLES)`.
  - Tick is asserted when `cnt==TICK_CYCLES-1`; `cnt` then returns to 0.
- On a press:
  - `o_Mode` becomes `o_Mode+1`, mod 4.
  - `cnt` clears to 0.
  - `dir` resets to up.
  - `o_LED` loads the initial pattern of the new mode: OFF 0000, BLINK 1111, CHASE 0001, BOUNCE 0001.
- On a tick, per mode:
  - OFF: `o_LED` holds 0000. The counter still runs and `o_Tick` still pulses.
  - BLINK: `o_LED` becomes `~o_LED`.
  - CHASE: rotate left, so 0001→0010→0100→1000→0001.
  - BOUNCE: shift in the `dir` direction. On the step into 1000, `dir` becomes down; on the step into 0001, `dir` becomes up.
  - Full BOUNCE sequence: 0001,0010,0100,1000,0100,0010,0001,0010…
- Press and tick in the same cycle: the press wins. The tick is dropped, so `o_Tick` is 0 in that cycle's result.
- `o_LED` is always one of the legal patterns above. In CHASE and BOUNCE it is never 0000 and never has more than one bit set.

## Timing
- Reset values:
  - `o_LED` = 0000, `o_Mode` = 0, `o_Tick` = 0.
  - `cnt` = 0, `dir` = up.
  - `press_r` is loaded with the current `i_Press`, so a button held through reset release is not counted as a press.
- Press latency: a press sampled at edge N updates `o_Mode` and `o_LED` at edge N+1. The first pattern step after it comes `TICK_CYCLES` cycles later.
- Tick period is exactly `TICK_CYCLES` cycles when no press occurs. `o_Tick` and the `o_LED` update appear on the same edge.
- Reset asserted mid-pattern: all state returns to reset values on the next edge, regardless of mode, `cnt` or `dir`.
- Back-to-back presses need `i_Press` to fall between them. Each rising edge advances exactly one mode.

## Configuration
- `LED_SEQ_PAUSE_EN` defined:
  - Adds the `i_Pause` port.
  - While `i_Pause==1`, `cnt`, `o_LED` and `dir` hold, and `o_Tick` stays 0.
  - Presses are still honoured during pause: the mode changes and the initial pattern loads, but no stepping occurs until pause drops.
  - Counting resumes from the held `cnt` value.
- `LED_SEQ_PAUSE_EN` not defined:
  - The port is absent and the block behaves as if `i_Pause==0`.

## Structure
- Shared package `led_seq_pkg`:
  - Mode enum: `MODE_OFF`, `MODE_BLINK`, `MODE_CHASE`, `MODE_BOUNCE`.
  - Initial-pattern constants.
  - LED width constant `LED_N = 4`.
- Sub-module `tick_gen`:
  - Parameter `TICK_CYCLES`.
  - Inputs: clk, rst, clear, hold.
  - Output: tick pulse.
  - Contains the counter only.
- The top module holds press detect, the mode register and the pattern/direction state machine.

## Test plan
All tests use `TICK_CYCLES=4`.
- Reset with `i_Press` held high, then release reset → `o_Mode` stays 0, `o_LED`=0000, no mode change.
- One press → next edge `o_Mode`=1, `o_LED`=1111. Four cycles later `o_Tick`=1 and `o_LED`=0000; four cycles after that, 1111.
- Two more presses → mode 3 (BOUNCE). Over 8 ticks, `o_LED` = 0010,0100,1000,0100,0010,0001,0010,0100.
- Press from mode 3 → wraps to mode 0, `o_LED`=0000. Press again → mode 1.
- Press coincident with `cnt==3` in CHASE → mode 3 loads 0001, `o_Tick` stays 0, next step after 4 cycles.
- With `LED_SEQ_PAUSE_EN`: in CHASE, set `i_Pause`=1 for 10 cycles → `o_LED` frozen and no `o_Tick`. Release → step occurs after the remaining count, not after a full 4 cycles.
